fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Program-counter and fetch-control stage sitting directly upstream of the 16-entry branch-target lookup table. Each cycle it drives the lookup index from the branch-index field of the current instruction. It consumes the returned constant as an absolute or PC-relative target. It sequences the PC through idle, run and halted states with a start/done handshake and counts retired instructions for the test harness.

## Interface
- PC_WIDTH, 16, width of PC, LUT target and start address
- CNT_WIDTH, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin execution at start_addr (sampled in IDLE/HALTED)
- start_addr  in  PC_WIDTH  first PC after start
- stall  in  1  hold PC and counters this cycle
- halt_req  in  1  decoded halt instruction at current PC
- branch_en  in  1  branch taken at current PC
- branch_rel  in  1  1 = pc + target, 0 = target
- branch_idx  in  4  branch-index field of current instruction
- lut_idx  out  4  index to lookup table
- lut_target  in  PC_WIDTH  lookup table output (combinational, same cycle)
- pc  out  PC_WIDTH  current fetch address
- pc_valid  out  1  pc is a live fetch address
- done  out  1  program halted
- retired  out  CNT_WIDTH  instructions retired since last start

## Operation
- States: IDLE, RUN, HALTED; encoding 2 bits, IDLE=0, RUN=1, HALTED=2, value 3 returns to IDLE.
- IDLE: pc_valid=0, done=0. On start, pc<=start_addr, retired<=0, go to RUN.
- RUN: pc_valid=1. Per cycle, priority: stall > halt_req > branch_en > sequential.
  - stall=1: pc, retired, state held; halt_req/branch_en ignored.
  - halt_req=1: state<=HALTED, pc held, retired+1.
  - branch_en=1: pc<=branch_rel ? pc+lut_target : lut_target, retired+1.
  - otherwise pc<=pc+1, retired+1.
  - start is ignored in RUN.
- HALTED: done=1, pc_valid=0, pc and retired held. On start, the same action as IDLE start occurs: reload, clear retired, go to RUN, done drops the next cycle.
- lut_idx = branch_idx combinationally in every state. There is no register between this block and the LUT.
- Arithmetic: all PC adds are modulo 2^PC_WIDTH; 0xFFFF+1 = 0x0000. Relative targets are two's-complement in PC_WIDTH bits, so 0xFFFE means -2.
- retired saturates at all-ones and does not wrap.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE, pc=0, retired=0, pc_valid=0, done=0. Deassertion is synchronous to clk in the surrounding design.
- Reset mid-RUN: outputs go to reset values immediately and no further fetches occur.
- start to first valid pc: 1 cycle. start is sampled at edge N, and pc=start_addr with pc_valid=1 after edge N.
- Branch/sequential update: new pc is visible after the edge at which the decision is sampled, giving 1-cycle latency and no bubble.
- halt_req at edge N: done=1 and pc_valid=0 after edge N. The halting instruction counts as retired.
- Simultaneous halt_req and branch_en: halt wins and the branch is discarded.
- Simultaneous stall and any other input: stall wins.

## Structure
- Shared package (processor-wide) holds:
  - the state enum fetch_state_t;
  - the LUT index width constant LUT_IDX_W = 4;
  - the default PC_WIDTH.
- Single module, no sub-modules. The lookup table is instantiated beside this block at top level, not inside it.
- One always_ff for state/pc/retired and one always_comb for next-state/next-pc.

## Test plan
- Reset/start: hold reset_n low, then release. Check pc=0, pc_valid=0, done=0. Pulse start with start_addr=0x0010. After one edge, check pc=0x0010 and pc_valid=1. Run 3 cycles to pc=0x0013, retired=3.
- Absolute branch: the LUT ties entry 5 to 0x0040. At pc=0x0013, drive branch_idx=5, branch_en=1, branch_rel=0. Check lut_idx=5 the same cycle and pc=0x0040 the next.
- Relative branch with wrap:
  - Backward: LUT entry 2 = 0xFFFE. At pc=0x0040, set branch_rel=1. Check pc becomes 0x003E.
  - Forward wrap: start at 0xFFFF with no branch. Check the next pc is 0x0000.
- Stall priority: at pc=0x0020, assert stall, halt_req and branch_en together for 2 cycles. Check pc stays 0x0020 and retired is unchanged. Drop stall while keeping halt_req and branch_en. Check done=1, pc=0x0020, and that retired increments by 1.
- Restart from HALTED: while done=1, pulse start with start_addr=0x0100. Check done=0, pc=0x0100 and retired=0 after one edge.
- Async reset mid-RUN: drop reset_n between clock edges while in RUN. Check pc=0, pc_valid=0 and retired=0 before the next edge.
- Counter saturation: with CNT_WIDTH=4, run 20 sequential cycles and check retired=0xF.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Processor-wide shared types and constants for the fetch front end.
package fetch_pc_ctrl_pkg;

  localparam int unsigned LUT_IDX_W        = 4;
  localparam int unsigned PC_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// PC sequencer for the fetch stage: idle/run/halted control, branch target
// selection from the external lookup table, and a saturating retire counter.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_addr,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 branch_en,
  input  logic                 branch_rel,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [LUT_IDX_W-1:0] lut_idx,
  input  logic [PC_WIDTH-1:0]  lut_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_valid,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] retired
);

  fetch_state_t         state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CNT_WIDTH-1:0] retired_inc;
  logic                 pc_valid_q, pc_valid_d;
  logic                 done_q, done_d;

  // The lookup table sits beside this block and answers in the same cycle.
  assign lut_idx = branch_idx;

  assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_d      = start_addr;
          retired_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Priority: stall > halt > branch > sequential.
        if (!stall) begin
          retired_d = retired_inc;
          if (halt_req) begin
            state_d = ST_HALTED;
          end else if (branch_en) begin
            pc_d = branch_rel ? pc_q + lut_target : lut_target;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pc_valid_d = (state_d == ST_RUN);
    done_d     = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      retired_q  <= '0;
      pc_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      pc_valid_q <= pc_valid_d;
      done_q     <= done_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign done     = done_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; a second copy with a 4-bit counter
// shares all inputs to exercise retire-count saturation.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] start_addr;
  logic        stall;
  logic        halt_req;
  logic        branch_en;
  logic        branch_rel;
  logic [3:0]  branch_idx;
  logic [3:0]  lut_idx;
  logic [15:0] lut_target;
  logic [15:0] pc;
  logic        pc_valid;
  logic        done;
  logic [15:0] retired;

  logic [3:0]  lut_idx_s;
  logic [15:0] pc_s;
  logic        pc_valid_s;
  logic        done_s;
  logic [3:0]  retired_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Branch-target table model driven by the DUT's index output.
  always_comb begin
    case (lut_idx)
      4'd2:    lut_target = 16'hFFFE;
      4'd5:    lut_target = 16'h0040;
      4'd7:    lut_target = 16'h0020;
      default: lut_target = 16'h0000;
    endcase
  end

  fetch_pc_ctrl #(.PC_WIDTH(16), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .halt_req(halt_req), .branch_en(branch_en),
    .branch_rel(branch_rel), .branch_idx(branch_idx), .lut_idx(lut_idx),
    .lut_target(lut_target), .pc(pc), .pc_valid(pc_valid), .done(done),
    .retired(retired)
  );

  fetch_pc_ctrl #(.PC_WIDTH(16), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .halt_req(halt_req), .branch_en(branch_en),
    .branch_rel(branch_rel), .branch_idx(branch_idx), .lut_idx(lut_idx_s),
    .lut_target(lut_target), .pc(pc_s), .pc_valid(pc_valid_s), .done(done_s),
    .retired(retired_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
    halt_req = 1'b0; branch_en = 1'b0; branch_rel = 1'b0; branch_idx = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_pc_valid got=%b exp=0", pc_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_start_seq();
    start = 1'b1; start_addr = 16'h0010;
    tick();
    start = 1'b0;
    total++; if (pc !== 16'h0010) begin bad++; $display("FAIL start_pc got=%h exp=0010", pc); end
    total++; if (pc_valid !== 1'b1) begin bad++; $display("FAIL start_pc_valid got=%b exp=1", pc_valid); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL start_retired got=%0d exp=0", retired); end
    tick(); tick(); tick();
    total++; if (pc !== 16'h0013) begin bad++; $display("FAIL seq_pc got=%h exp=0013", pc); end
    total++; if (retired !== 16'd3) begin bad++; $display("FAIL seq_retired got=%0d exp=3", retired); end
  endtask

  task automatic test_abs_branch();
    branch_idx = 4'd5; branch_en = 1'b1; branch_rel = 1'b0;
    #1;
    total++; if (lut_idx !== 4'd5) begin bad++; $display("FAIL abs_lut_idx got=%0d exp=5", lut_idx); end
    tick();
    branch_en = 1'b0;
    total++; if (pc !== 16'h0040) begin bad++; $display("FAIL abs_pc got=%h exp=0040", pc); end
    total++; if (retired !== 16'd4) begin bad++; $display("FAIL abs_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_rel_branch();
    branch_idx = 4'd2; branch_en = 1'b1; branch_rel = 1'b1;
    tick();
    branch_en = 1'b0; branch_rel = 1'b0;
    total++; if (pc !== 16'h003E) begin bad++; $display("FAIL rel_back_pc got=%h exp=003e", pc); end
    total++; if (retired !== 16'd5) begin bad++; $display("FAIL rel_retired got=%0d exp=5", retired); end
  endtask

  task automatic test_halt_and_wrap();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b exp=1", done); end
    total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL halt_pc_valid got=%b exp=0", pc_valid); end
    total++; if (pc !== 16'h003E) begin bad++; $display("FAIL halt_pc got=%h exp=003e", pc); end
    total++; if (retired !== 16'd6) begin bad++; $display("FAIL halt_retired got=%0d exp=6", retired); end
    tick();
    total++; if (done !== 1'b1 || pc !== 16'h003E) begin bad++; $display("FAIL halt_hold got done=%b pc=%h exp done=1 pc=003e", done, pc); end
    start = 1'b1; start_addr = 16'hFFFF;
    tick();
    start = 1'b0;
    total++; if (pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_start_pc got=%h exp=ffff", pc); end
    tick();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    total++; if (retired !== 16'd1) begin bad++; $display("FAIL wrap_retired got=%0d exp=1", retired); end
    start = 1'b1; start_addr = 16'h1234;
    tick();
    start = 1'b0;
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL run_ignores_start got=%h exp=0001", pc); end
  endtask

  task automatic test_stall_priority();
    branch_idx = 4'd7; branch_en = 1'b1; branch_rel = 1'b0;
    tick();
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL stall_setup_pc got=%h exp=0020", pc); end
    stall = 1'b1; halt_req = 1'b1; branch_idx = 4'd5;
    tick(); tick();
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL stall_pc got=%h exp=0020", pc); end
    total++; if (retired !== 16'd3) begin bad++; $display("FAIL stall_retired got=%0d exp=3", retired); end
    total++; if (pc_valid !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL stall_state got valid=%b done=%b exp 1/0", pc_valid, done); end
    stall = 1'b0;
    tick();
    halt_req = 1'b0; branch_en = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_over_branch_done got=%b exp=1", done); end
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL halt_over_branch_pc got=%h exp=0020", pc); end
    total++; if (retired !== 16'd4) begin bad++; $display("FAIL halt_over_branch_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_restart();
    start = 1'b1; start_addr = 16'h0100;
    tick();
    start = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_done got=%b exp=0", done); end
    total++; if (pc !== 16'h0100) begin bad++; $display("FAIL restart_pc got=%h exp=0100", pc); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL restart_retired got=%0d exp=0", retired); end
    total++; if (pc_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b exp=1", pc_valid); end
  endtask

  task automatic test_async_reset();
    tick();
    total++; if (pc !== 16'h0101) begin bad++; $display("FAIL pre_reset_pc got=%h exp=0101", pc); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL async_pc got=%h exp=0000", pc); end
    total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", pc_valid); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL async_retired got=%0d exp=0", retired); end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (pc_valid !== 1'b0 || pc !== 16'h0000) begin bad++; $display("FAIL post_reset_idle got valid=%b pc=%h exp 0/0000", pc_valid, pc); end
  endtask

  task automatic test_saturation();
    start = 1'b1; start_addr = 16'h0000;
    tick();
    start = 1'b0;
    total++; if (retired_s !== 4'd0) begin bad++; $display("FAIL sat_start got=%0d exp=0", retired_s); end
    for (int i = 0; i < 20; i++) tick();
    total++; if (retired_s !== 4'hF) begin bad++; $display("FAIL sat_retired got=%h exp=f", retired_s); end
    total++; if (retired !== 16'd20) begin bad++; $display("FAIL wide_retired got=%0d exp=20", retired); end
    total++; if (pc !== 16'd20) begin bad++; $display("FAIL sat_pc got=%h exp=0014", pc); end
  endtask

  initial begin
    test_reset();
    test_start_seq();
    test_abs_branch();
    test_rel_branch();
    test_halt_and_wrap();
    test_stall_priority();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
